axis_deadlock_watchdog: RTL and testbench
=========================================

# axis_deadlock_watchdog

Run-time deadlock watchdog and report scheduler for the AXI-Stream deadlock monitoring used in C/RTL co-simulation of the Sobel kernel. It qualifies the per-channel AXIS block indications against process idle status, times persistent stalls, and decides when a stall becomes a declared deadlock. It then hands one latched report (blocked-channel mask, optional cycle stamp) to the testbench collector over a valid/ready handshake. It sits above the per-instance deadlock monitors and is the only block that turns their raw block levels into a reported event.

## Interface
- NUM_CH, 3, number of monitored AXIS channels
- THRESH, 1024, consecutive qualified-blocked cycles required to declare deadlock; must be 2..2^CNT_W-1 (elaboration error otherwise)
- CNT_W, 16, stall counter width
- TS_W, 32, cycle-stamp width (used only with DEADLOCK_CYCLE_STAMP_EN)

- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- enable  in  1  watchdog enable
- axis_block_sigs  in  NUM_CH  per-channel AXIS block level
- inst_idle_sigs  in  NUM_CH  per-channel owning-instance idle level
- report_valid  out  1  report payload valid
- report_ready  in  1  collector accepts report
- report_mask  out  NUM_CH  sticky OR of channels blocked during the stall
- report_stamp  out  TS_W  free-running cycle count at detection (macro only)
- deadlock  out  1  level, high in REPORT and HOLD
- stall_cnt  out  CNT_W  current consecutive-blocked count

## Operation
- qual = axis_block_sigs & ~inst_idle_sigs; blocked = |qual. Channels whose instance is idle never count.
- States: IDLE, WATCH, SUSPECT, REPORT, HOLD. Reset state IDLE.
- IDLE: counter and mask cleared; enable=1 -> WATCH.
- WATCH: blocked -> SUSPECT, stall_cnt<=1, mask<=qual.
- SUSPECT: blocked -> stall_cnt+1, mask|=qual; if stall_cnt+1==THRESH -> REPORT (capture stamp). Not blocked -> WATCH, count and mask cleared.
- REPORT: report_valid=1; mask and stamp frozen; stall_cnt saturates at THRESH. report_valid&report_ready -> HOLD.
- HOLD: deadlock stays 1; first cycle with blocked=0 -> WATCH, count/mask cleared.
- enable=0 in WATCH/SUSPECT/HOLD -> IDLE next edge. In REPORT enable is ignored until the handshake completes, then IDLE if enable still 0, else HOLD.
- Arithmetic: stall_cnt never exceeds THRESH and never wraps; stamp counter wraps modulo 2^TS_W.

## Timing
- All outputs registered. Reset values: report_valid=0, deadlock=0, report_mask=0, stall_cnt=0, report_stamp=0.
- Continuous blocked from the first sampling edge: report_valid and deadlock rise exactly THRESH edges later.
- Once report_valid=1 it holds, payload stable, until sampled with report_ready=1; it drops the following cycle. Ready may be high before valid; no combinational ready->valid path.
- blocked dropping while in REPORT does not cancel the report.
- Single-cycle blocked gap in SUSPECT restarts the count from zero.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous); any pending report is lost.

## Configuration
- DEADLOCK_CYCLE_STAMP_EN defined: TS_W-bit free-running counter from reset; its value on the SUSPECT->REPORT edge is latched into report_stamp and held until the next report.
- Not defined: no stamp counter is built; report_stamp is tied to 0.

## Test plan
- THRESH=4, axis_block_sigs=3'b010, idle=0 held from edge 0 -> report_valid=1 after edge 4, report_mask=3'b010, stall_cnt=4.
- Same stimulus with axis_block_sigs=3'b000 for one cycle after edge 2 -> count restarts; report only 4 edges after blocking resumes.
- axis_block_sigs=3'b111, inst_idle_sigs=3'b111 for 100 cycles -> deadlock stays 0, stall_cnt stays 0.
- Channel 0 blocked, channel 2 joins at count 2, report_ready low 5 cycles after report -> mask=3'b101, report_valid and payload stable throughout, drops one cycle after ready; deadlock stays high until blocked clears.
- reset asserted asynchronously in SUSPECT and in REPORT -> all outputs 0 before next clock edge; enable=0 in REPORT -> IDLE only after handshake.
- With DEADLOCK_CYCLE_STAMP_EN, blocking starts at cycle 10, THRESH=4 -> report_stamp=13; without macro report_stamp=0.

Source files
------------

// File: rtl/axis_deadlock_watchdog.sv
// Deadlock watchdog: qualifies AXIS block levels against instance idle, times stalls, hands one report over valid/ready.
// Optional DEADLOCK_CYCLE_STAMP_EN adds a free-running cycle stamp latched at detection.
module axis_deadlock_watchdog #(
    parameter int NUM_CH = 3,
    parameter int THRESH = 1024,
    parameter int CNT_W  = 16,
    parameter int TS_W   = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [NUM_CH-1:0] axis_block_sigs,
    input  logic [NUM_CH-1:0] inst_idle_sigs,
    output logic              report_valid,
    input  logic              report_ready,
    output logic [NUM_CH-1:0] report_mask,
    output logic [TS_W-1:0]   report_stamp,
    output logic              deadlock,
    output logic [CNT_W-1:0]  stall_cnt
);

    generate
        if (THRESH < 2 || longint'(THRESH) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_thresh
            $error("axis_deadlock_watchdog: THRESH must be 2..2^CNT_W-1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

    typedef enum logic [2:0] {IDLE, WATCH, SUSPECT, REPORT, HOLD} state_t;

    state_t            state, state_n;
    logic [NUM_CH-1:0] qual, mask_n;
    logic [CNT_W-1:0]  cnt_n;
    logic              blocked;

    // A channel only counts while its owning instance is busy.
    assign qual    = axis_block_sigs & ~inst_idle_sigs;
    assign blocked = |qual;

    always_comb begin
        state_n = state;
        cnt_n   = stall_cnt;
        mask_n  = report_mask;
        case (state)
            IDLE: begin
                cnt_n  = '0;
                mask_n = '0;
                if (enable) state_n = WATCH;
            end
            WATCH: begin
                if (!enable) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    mask_n  = '0;
                end else if (blocked) begin
                    state_n = SUSPECT;
                    cnt_n   = CNT_W'(1);
                    mask_n  = qual;
                end
            end
            SUSPECT: begin
                if (!enable) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    mask_n  = '0;
                end else if (blocked) begin
                    cnt_n  = stall_cnt + CNT_W'(1);
                    mask_n = report_mask | qual;
                    if (cnt_n == THRESH_C) state_n = REPORT;
                end else begin
                    state_n = WATCH;
                    cnt_n   = '0;
                    mask_n  = '0;
                end
            end
            REPORT: begin
                // Enable is only honoured once the collector has taken the report.
                if (report_ready) begin
                    if (enable) begin
                        state_n = HOLD;
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                        mask_n  = '0;
                    end
                end
            end
            HOLD: begin
                if (!enable) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    mask_n  = '0;
                end else if (!blocked) begin
                    state_n = WATCH;
                    cnt_n   = '0;
                    mask_n  = '0;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                mask_n  = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            stall_cnt    <= '0;
            report_mask  <= '0;
            report_valid <= 1'b0;
            deadlock     <= 1'b0;
        end else begin
            state        <= state_n;
            stall_cnt    <= cnt_n;
            report_mask  <= mask_n;
            report_valid <= (state_n == REPORT);
            deadlock     <= (state_n == REPORT) || (state_n == HOLD);
        end
    end

`ifdef DEADLOCK_CYCLE_STAMP_EN
    logic [TS_W-1:0] ts_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ts_cnt       <= '0;
            report_stamp <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
            if (state == SUSPECT && state_n == REPORT) report_stamp <= ts_cnt;
        end
    end
`else
    assign report_stamp = '0;
`endif

endmodule

// File: tb/tb_axis_deadlock_watchdog.sv
// Scoreboard bench for axis_deadlock_watchdog (THRESH=4); expected reports queued at stall start, popped on handshake.
module tb_axis_deadlock_watchdog;
    localparam int NUM_CH = 3;
    localparam int THRESH = 4;
    localparam int CNT_W  = 16;
    localparam int TS_W   = 32;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic              report_ready = 1'b0;
    logic [NUM_CH-1:0] axis_block_sigs = '0;
    logic [NUM_CH-1:0] inst_idle_sigs = '0;
    logic              report_valid, deadlock;
    logic [NUM_CH-1:0] report_mask;
    logic [TS_W-1:0]   report_stamp;
    logic [CNT_W-1:0]  stall_cnt;

    axis_deadlock_watchdog #(.NUM_CH(NUM_CH), .THRESH(THRESH), .CNT_W(CNT_W), .TS_W(TS_W)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .axis_block_sigs(axis_block_sigs), .inst_idle_sigs(inst_idle_sigs),
        .report_valid(report_valid), .report_ready(report_ready),
        .report_mask(report_mask), .report_stamp(report_stamp),
        .deadlock(deadlock), .stall_cnt(stall_cnt)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [NUM_CH-1:0] mask;
        logic [CNT_W-1:0]  cnt;
        logic [TS_W-1:0]   stamp;
    } rpt_t;
    rpt_t sb_q[$];
    rpt_t exp_r;

    // Edges since reset release; value at a negedge is the index of the next edge.
    logic [TS_W-1:0] ecnt;
    always @(posedge clock or posedge reset)
        if (reset) ecnt <= '0; else ecnt <= ecnt + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // first_edge: edge on which WATCH first samples the stall.
    task automatic push(input logic [NUM_CH-1:0] m, input logic [TS_W-1:0] first_edge);
        rpt_t r;
        r.mask = m;
        r.cnt  = CNT_W'(THRESH);
`ifdef DEADLOCK_CYCLE_STAMP_EN
        r.stamp = first_edge + TS_W'(THRESH - 1);
`else
        r.stamp = (first_edge == '1) ? '1 : '0;
        r.stamp = '0;
`endif
        sb_q.push_back(r);
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, report_valid, 0);
        chk({tag, "_dl"},    deadlock, 0);
        chk({tag, "_mask"},  report_mask, 0);
        chk({tag, "_cnt"},   stall_cnt, 0);
        chk({tag, "_stamp"}, report_stamp, 0);
    endtask

    // Handshake monitor: runs after the driver at each negedge, so it sees what the next edge will sample.
    logic              pv = 1'b0;
    logic [NUM_CH-1:0] pm;
    logic [TS_W-1:0]   ps;
    always @(negedge clock) begin
        #2;
        if (!reset && report_valid) begin
            if (pv) begin
                chk("hold_mask",  report_mask,  pm);
                chk("hold_stamp", report_stamp, ps);
            end
            pm = report_mask;
            ps = report_stamp;
            if (report_ready) begin
                if (sb_q.size() == 0) chk("sb_unexpected", 1, 0);
                else begin
                    exp_r = sb_q.pop_front();
                    chk("sb_mask",  report_mask,  exp_r.mask);
                    chk("sb_cnt",   stall_cnt,    exp_r.cnt);
                    chk("sb_stamp", report_stamp, exp_r.stamp);
                end
                pv = 1'b0;
            end else pv = 1'b1;
        end else pv = 1'b0;
    end

    initial begin
        repeat (2) step();
        chk_zero("reset");

        // Continuous stall on channel 1 from the first edge after reset.
        reset = 1'b0; enable = 1'b1; axis_block_sigs = 3'b010;
        push(3'b010, ecnt + 1);
        repeat (4) step();
        chk("t1_cnt3", stall_cnt, 3);
        chk("t1_novalid", report_valid, 0);
        step();
        chk("t1_valid", report_valid, 1);
        chk("t1_dl", deadlock, 1);
        chk("t1_mask", report_mask, 3'b010);
        chk("t1_cnt", stall_cnt, 4);
        report_ready = 1'b1;
        step();
        chk("t1_drop", report_valid, 0);
        chk("t1_hold_dl", deadlock, 1);
        axis_block_sigs = 3'b000;
        step();
        chk("t1_clear_dl", deadlock, 0);
        chk("t1_clear_cnt", stall_cnt, 0);
        chk("t1_clear_mask", report_mask, 0);

        // One-cycle gap restarts the count; ready already high before valid.
        axis_block_sigs = 3'b010;
        step(); step();
        chk("t2_cnt2", stall_cnt, 2);
        axis_block_sigs = 3'b000;
        step();
        chk("t2_restart", stall_cnt, 0);
        axis_block_sigs = 3'b010;
        push(3'b010, ecnt);
        repeat (3) step();
        chk("t2_cnt3", stall_cnt, 3);
        chk("t2_novalid", report_valid, 0);
        step();
        chk("t2_valid", report_valid, 1);
        chk("t2_cnt", stall_cnt, 4);
        step();
        chk("t2_drop", report_valid, 0);
        chk("t2_hold_dl", deadlock, 1);
        axis_block_sigs = 3'b000;
        step();
        chk("t2_clear_dl", deadlock, 0);

        // Blocked but idle instances never count.
        axis_block_sigs = 3'b111; inst_idle_sigs = 3'b111;
        for (int i = 0; i < 100; i++) begin
            step();
            chk("t3_dl", deadlock, 0);
            chk("t3_cnt", stall_cnt, 0);
        end
        axis_block_sigs = 3'b000; inst_idle_sigs = 3'b000;

        // Channel 2 joins mid-stall; collector stalls 5 cycles.
        report_ready = 1'b0;
        axis_block_sigs = 3'b001;
        push(3'b101, ecnt);
        step();
        chk("t4_cnt1", stall_cnt, 1);
        step();
        chk("t4_cnt2", stall_cnt, 2);
        axis_block_sigs = 3'b101;
        step();
        chk("t4_cnt3", stall_cnt, 3);
        chk("t4_mask3", report_mask, 3'b101);
        step();
        chk("t4_valid", report_valid, 1);
        chk("t4_mask", report_mask, 3'b101);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_wait_valid", report_valid, 1);
            chk("t4_wait_cnt", stall_cnt, 4);
        end
        report_ready = 1'b1;
        step();
        chk("t4_drop", report_valid, 0);
        chk("t4_hold_dl", deadlock, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_hold_dl_n", deadlock, 1);
        end
        axis_block_sigs = 3'b000;
        step();
        chk("t4_clear_dl", deadlock, 0);

        // Disable and unblock during REPORT: report survives, IDLE only after handshake.
        report_ready = 1'b0;
        axis_block_sigs = 3'b100;
        push(3'b100, ecnt);
        repeat (4) step();
        chk("t5_valid", report_valid, 1);
        enable = 1'b0; axis_block_sigs = 3'b000;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t5_keep_valid", report_valid, 1);
            chk("t5_keep_dl", deadlock, 1);
        end
        report_ready = 1'b1;
        step();
        chk("t5_idle_valid", report_valid, 0);
        chk("t5_idle_dl", deadlock, 0);
        chk("t5_idle_cnt", stall_cnt, 0);
        chk("t5_idle_mask", report_mask, 0);
        axis_block_sigs = 3'b010;
        step(); step();
        chk("t5_disabled_cnt", stall_cnt, 0);
        enable = 1'b1;
        step(); step();
        chk("t5_reen_cnt", stall_cnt, 1);

        // Asynchronous reset in SUSPECT.
        #3 reset = 1'b1;
        #1 chk_zero("t6_susp");
        @(negedge clock);
        reset = 1'b0; report_ready = 1'b0; axis_block_sigs = 3'b100;
        repeat (5) step();
        chk("t6_valid", report_valid, 1);
        // Asynchronous reset in REPORT: the pending report is dropped.
        #3 reset = 1'b1;
        #1 chk_zero("t6_rep");
        @(negedge clock);
        reset = 1'b0; axis_block_sigs = 3'b000;
        step(); step();
        chk("t6_after_valid", report_valid, 0);

        chk("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
